piradspi_target_engine: RTL and testbench
=========================================

Name: piradspi_target_engine

Overview:
- SPI target (slave) engine: the far-end counterpart of the PiRadSPI initiator engine.
- Oversamples external SCLK/CSN/MOSI on the system clock, deserializes MOSI into words on an AXI-stream-style master port, and serializes MISO from words on an AXI-stream-style slave port.
- Used for loopback verification of the initiator and as the SPI personality of Pi Radio companion FPGAs.

Parameters:
- DATA_WIDTH, 32, bits per stream word; shift order is MSB first.
- SYNC_STAGES, 2, flip-flop stages on each of sclk, csn and mosi; minimum 2.
- BIT_COUNT_WIDTH, 16, width of the per-transaction bit counter; saturates at all-ones.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- cpol  in  1  clock polarity; sampled when CSN assertion is detected.
- cpha  in  1  clock phase; sampled when CSN assertion is detected.
- sclk  in  1  SPI clock, asynchronous to clk.
- csn  in  1  active-low chip select, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- miso  out  1  SPI data out.
- miso_oe  out  1  high while selected; drives the pad tristate.
- s_axis_tdata  in  DATA_WIDTH  word to transmit.
- s_axis_tvalid  in  1  transmit word valid.
- s_axis_tready  out  1  transmit word accepted.
- m_axis_tdata  out  DATA_WIDTH  received word.
- m_axis_tvalid  out  1  received word valid.
- m_axis_tready  in  1  received word accepted.
- xfer_done  out  1  one-cycle pulse on transaction end.
- xfer_bits  out  BIT_COUNT_WIDTH  sclk sample edges in the last transaction; held until the next transaction ends.
- overrun  out  1  sticky: a received word was dropped; cleared at start of next transaction.
- underrun  out  1  sticky: a transmit word was missing; cleared at start of next transaction.

Behaviour:
- Reset values: miso=0, miso_oe=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, xfer_done=0, xfer_bits=0, overrun=0, underrun=0; state=IDLE. Synchronizer flops reset as if csn is high and sclk is at cpol.
- Inputs pass through SYNC_STAGES flops, then a 1-flop edge detector. Internal event latency is SYNC_STAGES+1 clk after the pin edge.
- Requirement on the peer: SCLK high and low phases each ≥ SYNC_STAGES+2 clk; CSN-to-first-SCLK-edge ≥ SYNC_STAGES+3 clk.
- Normalized clock is sclk^cpol. Leading edge = its rising edge; trailing edge = its falling edge.
  - cpha=0: sample MOSI on leading edge, shift MISO on trailing edge.
  - cpha=1: shift on leading edge, sample on trailing edge.
- States:
  - IDLE: miso_oe=0. On detected csn fall: latch cpol/cpha, clear bit counter, overrun and underrun → LOAD.
  - LOAD (1 cycle): s_axis_tready=1 for this cycle.
    - If s_axis_tvalid: load tx shift register.
    - Else: load all-zeros and set underrun.
    - Drive miso=tx[DATA_WIDTH-1] and miso_oe=1 → ACTIVE.
  - ACTIVE:
    - On sample edge: rx shift register ← {rx[DATA_WIDTH-2:0], mosi_sync}; bit counter +1, saturating; word bit index +1.
    - When the index wraps DATA_WIDTH→0, push the word to the output register.
    - On shift edge: tx ← tx<<1 and miso=new MSB, except when that edge completes a word. In that case, in the same cycle, do the reload handshake exactly as in LOAD (including underrun) and drive the new MSB.
    - cpha=1: the first leading edge after LOAD shifts nothing, because bit 0 was already driven.
    - Detected csn rise → END. csn rise takes priority over an SCLK edge detected in the same cycle; that edge is ignored.
  - END (1 cycle): miso_oe=0, miso=0, xfer_done=1, xfer_bits ← bit counter. A partial rx word is discarded (see optional feature) → IDLE.
- Receive output: a single holding register.
  - When a word completes and m_axis_tvalid=0, or m_axis_tvalid&m_axis_tready in that cycle: load the word and set tvalid.
  - Otherwise drop the new word and set overrun; the held word is kept.
  - tvalid clears on handshake without a new push. Holding data is unchanged while tvalid&~tready.
- s_axis_tready is never high outside LOAD or a word-boundary reload cycle.
- Reset mid-transaction: returns to IDLE; the pending rx word is lost. Reset behaves like CSN high.
- csn glitch shorter than SYNC_STAGES clk may be missed; no requirement on it.

Optional Feature:
- Macro PIRADSPI_TARGET_PARTIAL_FLUSH_EN.
- Defined: in END, if the word bit index is non-zero, push the partial word left-aligned (received bits in the MSBs, zeros below) through the same holding-register rules, including overrun.
- Not defined: partial words are discarded silently. xfer_bits still reports the true count.

Test Plan:
- Mode 0, 32 clk/half-period SCLK, 32 bits MOSI=0xA5C3_0F81, s_axis word 0x1234_5678 → m_axis word 0xA5C3_0F81; MISO bits read 0x1234_5678; xfer_done pulse; xfer_bits=32; no flags.
- Modes 1, 2 and 3, 64 bits, MOSI words 0xDEADBEEF then 0x0BADF00D, tx words 0xCAFEF00D then 0x87654321 → both words received in order and both transmitted; xfer_bits=64.
- s_axis_tvalid held low, mode 0, 32 bits → MISO all zeros; underrun=1; rx word still delivered.
- m_axis_tready=0, 96 bits sent → first word held; words 2 and 3 dropped; overrun=1; first word correct once tready rises.
- 12-bit transfer of 0xABC → xfer_bits=12. Macro defined: m_axis word 0xABC0_0000. Not defined: no word emitted.
- rstn low for 1 cycle after 10 of 32 bits → miso_oe=0 next cycle; no m_axis word. A following 32-bit transfer succeeds with xfer_bits=32.

Source files
------------

// File: rtl/piradspi_target_engine_if.sv
// Stream bundle between the PiRadSPI target engine and its user logic.
// The engine consumes transmit words on s_axis and produces received words on m_axis.
interface piradspi_target_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/piradspi_target_engine.sv
// SPI target engine: oversampled SCLK/CSN/MOSI, MSB-first word deserializer/serializer.
// Define PIRADSPI_TARGET_PARTIAL_FLUSH_EN to push a left-aligned partial word at transaction end.
module piradspi_target_engine #(
    parameter int DATA_WIDTH      = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int BIT_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cpol_i,
    input  logic                       cpha_i,
    input  logic                       sclk_i,
    input  logic                       csn_i,
    input  logic                       mosi_i,
    output logic                       miso_o,
    output logic                       miso_oe_o,
    piradspi_target_engine_if.slave    axis,
    output logic                       xfer_done_o,
    output logic [BIT_COUNT_WIDTH-1:0] xfer_bits_o,
    output logic                       overrun_o,
    output logic                       underrun_o
);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE, S_END} state_e;
    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, csn_prev_q;
    logic                   sclk_s, csn_s, mosi_s;
    logic                   csn_fall, csn_rise, lead, trail, sample_edge, shift_edge;

    logic                       cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DATA_WIDTH-1:0]      tx_q, tx_d, rx_q, rx_d, mdata_q, mdata_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [BIT_COUNT_WIDTH-1:0] bitcnt_q, bitcnt_d, xbits_q, xbits_d;
    logic                       miso_q, miso_d, oe_q, oe_d, mvalid_q, mvalid_d;
    logic                       done_q, done_d, ovr_q, ovr_d, und_q, und_d;
    logic                       s_tready, reload, push, m_hs;
    logic [DATA_WIDTH-1:0]      push_word, load_word;

    // Synchronizers reset to the idle pin levels so reset looks like CSN high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sclk_sync_q <= {SYNC_STAGES{cpol_i}};
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= cpol_i;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s       = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign csn_fall    = csn_prev_q & ~csn_s;
    assign csn_rise    = ~csn_prev_q & csn_s;
    assign lead        = (sclk_s ^ cpol_q) & ~(sclk_prev_q ^ cpol_q);
    assign trail       = ~(sclk_s ^ cpol_q) & (sclk_prev_q ^ cpol_q);
    assign sample_edge = cpha_q ? trail : lead;
    assign shift_edge  = cpha_q ? lead : trail;
    assign load_word   = axis.s_axis_tvalid ? axis.s_axis_tdata : '0;
    assign m_hs        = mvalid_q & axis.m_axis_tready;

`ifdef PIRADSPI_TARGET_PARTIAL_FLUSH_EN
    logic [IDX_W:0] flush_sh;
    assign flush_sh = (IDX_W+1)'(DATA_WIDTH) - {1'b0, idx_q};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (csn_fall) state_d = S_LOAD;
            S_LOAD:   state_d = csn_rise ? S_END : S_ACTIVE;
            S_ACTIVE: if (csn_rise) state_d = S_END;
            S_END:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        idx_d     = idx_q;
        bitcnt_d  = bitcnt_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        mvalid_d  = mvalid_q;
        mdata_d   = mdata_q;
        done_d    = 1'b0;
        xbits_d   = xbits_q;
        ovr_d     = ovr_q;
        und_d     = und_q;
        s_tready  = 1'b0;
        reload    = 1'b0;
        push      = 1'b0;
        push_word = rx_q;
        case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                if (csn_fall) begin
                    cpol_d   = cpol_i;
                    cpha_d   = cpha_i;
                    bitcnt_d = '0;
                    idx_d    = '0;
                    ovr_d    = 1'b0;
                    und_d    = 1'b0;
                end
            end
            S_LOAD: reload = 1'b1;
            S_ACTIVE: begin
                // A CSN rise wins over any SCLK edge seen in the same cycle.
                if (!csn_rise) begin
                    if (sample_edge) begin
                        rx_d = {rx_q[DATA_WIDTH-2:0], mosi_s};
                        if (bitcnt_q != '1) bitcnt_d = bitcnt_q + 1'b1;
                        if (idx_q == IDX_W'(DATA_WIDTH-1)) begin
                            idx_d     = '0;
                            push      = 1'b1;
                            push_word = rx_d;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (shift_edge && idx_q != '0) begin
                        tx_d   = tx_q << 1;
                        miso_d = tx_d[DATA_WIDTH-1];
                    end else if (shift_edge && bitcnt_q != '0) begin
                        reload = 1'b1;
                    end
                end
            end
            S_END: begin
                miso_d  = 1'b0;
                oe_d    = 1'b0;
                done_d  = 1'b1;
                xbits_d = bitcnt_q;
`ifdef PIRADSPI_TARGET_PARTIAL_FLUSH_EN
                if (idx_q != '0) begin
                    push      = 1'b1;
                    push_word = rx_q << flush_sh;
                end
`endif
            end
            default: ;
        endcase

        if (reload) begin
            s_tready = 1'b1;
            tx_d     = load_word;
            miso_d   = load_word[DATA_WIDTH-1];
            oe_d     = 1'b1;
            if (!axis.s_axis_tvalid) und_d = 1'b1;
        end

        // Single holding register: a new word only lands if the slot is free or draining now.
        if (push) begin
            if (!mvalid_q || m_hs) begin
                mdata_d  = push_word;
                mvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (m_hs) begin
            mvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            idx_q    <= '0;
            bitcnt_q <= '0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            done_q   <= 1'b0;
            xbits_q  <= '0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            idx_q    <= idx_d;
            bitcnt_q <= bitcnt_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            done_q   <= done_d;
            xbits_q  <= xbits_d;
            ovr_q    <= ovr_d;
            und_q    <= und_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

    assign miso_o             = miso_q;
    assign miso_oe_o          = oe_q;
    assign axis.s_axis_tready = s_tready;
    assign axis.m_axis_tdata  = mdata_q;
    assign axis.m_axis_tvalid = mvalid_q;
    assign xfer_done_o        = done_q;
    assign xfer_bits_o        = xbits_q;
    assign overrun_o          = ovr_q;
    assign underrun_o         = und_q;
endmodule

// File: tb/tb_piradspi_target_engine.sv
// Directed bench for piradspi_target_engine: bit-bangs SPI transactions in all modes
// and checks stream words, MISO bits, flags and transaction reporting.
module tb_piradspi_target_engine;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, cpol, cpha, sclk, csn, mosi;
    logic        miso, miso_oe, xfer_done, overrun, underrun;
    logic [15:0] xfer_bits;

    piradspi_target_engine_if #(.DATA_WIDTH(DW)) axis ();

    piradspi_target_engine #(
        .DATA_WIDTH(DW), .SYNC_STAGES(2), .BIT_COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rstn(rstn), .cpol_i(cpol), .cpha_i(cpha), .sclk_i(sclk),
        .csn_i(csn), .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe),
        .axis(axis), .xfer_done_o(xfer_done), .xfer_bits_o(xfer_bits),
        .overrun_o(overrun), .underrun_o(underrun)
    );

    logic [31:0]  txq[$];
    logic [31:0]  rx_got[$];
    int           done_cnt, tests, fails;
    logic [127:0] mi;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got(input int k);
        if (k < rx_got.size()) return rx_got[k];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic drive_s();
        if (txq.size() > 0) begin
            axis.s_axis_tvalid = 1'b1;
            axis.s_axis_tdata  = txq[0];
        end else begin
            axis.s_axis_tvalid = 1'b0;
            axis.s_axis_tdata  = '0;
        end
    endtask

    // One clock: observe handshakes at the falling edge, update the source after the rising edge.
    task automatic tick();
        logic hs_s;
        @(negedge clk);
        hs_s = axis.s_axis_tready & axis.s_axis_tvalid;
        if (axis.m_axis_tvalid && axis.m_axis_tready) rx_got.push_back(axis.m_axis_tdata);
        if (xfer_done) done_cnt++;
        @(posedge clk);
        #1;
        if (hs_s && txq.size() > 0) void'(txq.pop_front());
        drive_s();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic spi_xfer(input logic m_cpol, input logic m_cpha, input int nbits, input int half,
                            input logic [127:0] mo, input int rst_at, output logic [127:0] mo_in);
        bit aborted;
        aborted = 1'b0;
        mo_in   = '0;
        cpol = m_cpol;
        cpha = m_cpha;
        sclk = m_cpol;
        ticks(8);
        done_cnt = 0;
        csn = 1'b0;
        ticks(8);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rstn = 1'b0;
                csn  = 1'b1;
                tick();
                rstn = 1'b1;
                check("rst_oe_low", 64'(miso_oe), 64'd0);
                aborted = 1'b1;
                break;
            end
            if (!m_cpha) begin
                mosi = mo[nbits-1-i];
                ticks(half);
                sclk = ~m_cpol;
                mo_in[nbits-1-i] = miso;
                ticks(half);
                sclk = m_cpol;
            end else begin
                sclk = ~m_cpol;
                mosi = mo[nbits-1-i];
                ticks(half);
                sclk = m_cpol;
                mo_in[nbits-1-i] = miso;
                ticks(half);
            end
        end
        if (!aborted) begin
            if (!m_cpha) ticks(half);
            csn = 1'b1;
        end
        ticks(8);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        done_cnt = 0;
        rstn = 1'b0;
        csn  = 1'b1;
        cpol = 1'b0;
        cpha = 1'b0;
        sclk = 1'b0;
        mosi = 1'b0;
        axis.s_axis_tvalid = 1'b0;
        axis.s_axis_tdata  = '0;
        axis.m_axis_tready = 1'b1;
        ticks(3);
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_oe", 64'(miso_oe), 64'd0);
        check("rst_s_tready", 64'(axis.s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
        check("rst_m_tdata", 64'(axis.m_axis_tdata), 64'd0);
        check("rst_done", 64'(xfer_done), 64'd0);
        check("rst_bits", 64'(xfer_bits), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);
        check("rst_und", 64'(underrun), 64'd0);
        rstn = 1'b1;
        ticks(3);

        // Mode 0, slow SCLK, one word each way (second tx word feeds the closing reload).
        txq.delete(); txq.push_back(32'h1234_5678); txq.push_back(32'h0); drive_s();
        rx_got.delete();
        spi_xfer(1'b0, 1'b0, 32, 32, 128'hA5C3_0F81, -1, mi);
        check("m0_rx_cnt", 64'(rx_got.size()), 64'd1);
        check("m0_rx", 64'(got(0)), 64'hA5C3_0F81);
        check("m0_miso", 64'(mi[31:0]), 64'h1234_5678);
        check("m0_done", 64'(done_cnt), 64'd1);
        check("m0_bits", 64'(xfer_bits), 64'd32);
        check("m0_ovr", 64'(overrun), 64'd0);
        check("m0_und", 64'(underrun), 64'd0);

        for (int m = 1; m < 4; m++) begin
            logic mp, mh;
            mp = (m >= 2);
            mh = (m == 1 || m == 3);
            txq.delete();
            txq.push_back(32'hCAFE_F00D); txq.push_back(32'h8765_4321); txq.push_back(32'h0);
            drive_s();
            rx_got.delete();
            spi_xfer(mp, mh, 64, 8, {64'h0, 32'hDEAD_BEEF, 32'h0BAD_F00D}, -1, mi);
            check($sformatf("m%0d_rx_cnt", m), 64'(rx_got.size()), 64'd2);
            check($sformatf("m%0d_rx0", m), 64'(got(0)), 64'hDEAD_BEEF);
            check($sformatf("m%0d_rx1", m), 64'(got(1)), 64'h0BAD_F00D);
            check($sformatf("m%0d_miso", m), mi[63:0], 64'hCAFE_F00D_8765_4321);
            check($sformatf("m%0d_bits", m), 64'(xfer_bits), 64'd64);
            check($sformatf("m%0d_und", m), 64'(underrun), 64'd0);
        end

        // No transmit data available at all.
        txq.delete(); drive_s();
        rx_got.delete();
        spi_xfer(1'b0, 1'b0, 32, 8, 128'h1357_9BDF, -1, mi);
        check("und_miso", 64'(mi[31:0]), 64'd0);
        check("und_flag", 64'(underrun), 64'd1);
        check("und_rx", 64'(got(0)), 64'h1357_9BDF);
        check("und_ovr", 64'(overrun), 64'd0);

        // Receiver stalled for three words.
        txq.delete();
        txq.push_back(32'h1); txq.push_back(32'h2); txq.push_back(32'h3); txq.push_back(32'h4);
        drive_s();
        rx_got.delete();
        axis.m_axis_tready = 1'b0;
        spi_xfer(1'b0, 1'b0, 96, 8, {32'h0, 32'h0123_4567, 32'h89AB_CDEF, 32'h7654_3210}, -1, mi);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_und_cleared", 64'(underrun), 64'd0);
        check("ovr_none_out", 64'(rx_got.size()), 64'd0);
        check("ovr_held_vld", 64'(axis.m_axis_tvalid), 64'd1);
        check("ovr_bits", 64'(xfer_bits), 64'd96);
        axis.m_axis_tready = 1'b1;
        ticks(2);
        check("ovr_rx_cnt", 64'(rx_got.size()), 64'd1);
        check("ovr_rx", 64'(got(0)), 64'h0123_4567);
        check("ovr_vld_clr", 64'(axis.m_axis_tvalid), 64'd0);

        // Partial 12-bit transaction.
        txq.delete(); txq.push_back(32'hF0F0_A5A5); drive_s();
        rx_got.delete();
        spi_xfer(1'b0, 1'b0, 12, 8, 128'hABC, -1, mi);
        check("p12_bits", 64'(xfer_bits), 64'd12);
        check("p12_done", 64'(done_cnt), 64'd1);
        check("p12_miso", 64'(mi[11:0]), 64'hF0F);
        check("p12_ovr", 64'(overrun), 64'd0);
`ifdef PIRADSPI_TARGET_PARTIAL_FLUSH_EN
        check("p12_cnt", 64'(rx_got.size()), 64'd1);
        check("p12_word", 64'(got(0)), 64'hABC0_0000);
`else
        check("p12_cnt", 64'(rx_got.size()), 64'd0);
`endif

        // Reset after 10 bits, then a clean transfer.
        txq.delete(); txq.push_back(32'h1122_3344); drive_s();
        rx_got.delete();
        spi_xfer(1'b0, 1'b0, 32, 8, 128'hFFFF_FFFF, 10, mi);
        ticks(10);
        check("rst_mid_cnt", 64'(rx_got.size()), 64'd0);
        check("rst_mid_vld", 64'(axis.m_axis_tvalid), 64'd0);
        check("rst_mid_done", 64'(done_cnt), 64'd0);
        check("rst_mid_oe", 64'(miso_oe), 64'd0);
        txq.delete(); txq.push_back(32'h55AA_55AA); txq.push_back(32'h0); drive_s();
        rx_got.delete();
        spi_xfer(1'b0, 1'b0, 32, 8, 128'h3C3C_C3C3, -1, mi);
        check("post_rst_bits", 64'(xfer_bits), 64'd32);
        check("post_rst_rx", 64'(got(0)), 64'h3C3C_C3C3);
        check("post_rst_miso", 64'(mi[31:0]), 64'h55AA_55AA);
        check("post_rst_done", 64'(done_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
